// File: rtl/pq_access_scheduler.sv
// Round-robin access scheduler that shares one register-tree max-heap priority queue
// among NUM_REQ requesters. It issues enq/deq/replace commands, then waits for the tree to settle.
module pq_access_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 12
) (
  input  logic                                 i_CLK,
  input  logic                                 i_RSTn,
  input  logic [NUM_REQ-1:0]                   i_req_valid,
  input  logic [NUM_REQ-1:0][1:0]              i_req_op,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]                   o_req_ready,
  output logic [NUM_REQ-1:0]                   o_rsp_valid,
  output logic [DATA_WIDTH-1:0]                o_rsp_data,
  output logic                                 o_drop,
  output logic                                 o_busy,
  output logic                                 o_pq_wrt,
  output logic                                 o_pq_read,
  output logic [DATA_WIDTH-1:0]                o_pq_data,
  input  logic                                 i_pq_full,
  input  logic                                 i_pq_empty,
  input  logic [DATA_WIDTH-1:0]                i_pq_top
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

  localparam logic [1:0] OP_ENQ = 2'b01;
  localparam logic [1:0] OP_DEQ = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE} state_t;

  state_t                 r_state;
  logic [IDW-1:0]         r_rr;
  logic [IDW-1:0]         r_id;
  logic                   r_need_rsp;
  logic [CW-1:0]          r_cnt;
  logic                   r_pq_wrt;
  logic                   r_pq_read;
  logic [DATA_WIDTH-1:0]  r_pq_data;
  logic [NUM_REQ-1:0]     r_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_rsp_data;
  logic                   r_drop;

  logic [NUM_REQ-1:0]     w_eligible;
  logic [IDW:0]           w_cand;
  logic                   w_grant_vld;
  logic [IDW-1:0]         w_grant_id;
  logic [1:0]             w_grant_op;
  logic [DATA_WIDTH-1:0]  w_grant_data;
  logic                   w_grant_drop;

  // NOTE: every combinational output gets a default at the top of the block, so no path infers a latch.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      case (i_req_op[i])
        OP_ENQ:  w_eligible[i] = i_req_valid[i] & ~i_pq_full;
        OP_DEQ:  w_eligible[i] = i_req_valid[i] & ~i_pq_empty;
        default: w_eligible[i] = i_req_valid[i];
      endcase
    end
  end

  // Search starts one past the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = {1'b0, r_rr} + (IDW+1)'(i);
      if (w_cand >= (IDW+1)'(NUM_REQ))
        w_cand = w_cand - (IDW+1)'(NUM_REQ);
      if (!w_grant_vld && w_eligible[w_cand[IDW-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_cand[IDW-1:0];
      end
    end
  end

  assign w_grant_op   = i_req_op[w_grant_id];
  assign w_grant_data = i_req_data[w_grant_id];
  // A zero key would read as an empty slot in the heap, so it is discarded like an illegal op.
  assign w_grant_drop = (w_grant_op == 2'b00) || (w_grant_op[0] && (w_grant_data == '0));

  assign o_req_ready = (i_RSTn && (r_state == S_IDLE) && w_grant_vld)
                       ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign o_busy      = (r_state != S_IDLE);
  assign o_pq_wrt    = r_pq_wrt;
  assign o_pq_read   = r_pq_read;
  assign o_pq_data   = r_pq_data;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_drop      = r_drop;

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_state     <= S_IDLE;
      r_rr        <= IDW'(NUM_REQ - 1);
      r_id        <= '0;
      r_need_rsp  <= 1'b0;
      r_cnt       <= '0;
      r_pq_wrt    <= 1'b0;
      r_pq_read   <= 1'b0;
      r_pq_data   <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_drop      <= 1'b0;
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_rr <= w_grant_id;
            r_id <= w_grant_id;
            if (w_grant_drop) begin
              r_drop <= 1'b1;
            end else begin
              r_state    <= S_ISSUE;
              r_need_rsp <= w_grant_op[1];
              r_pq_wrt   <= w_grant_op[0];
              r_pq_read  <= w_grant_op[1];
              r_pq_data  <= w_grant_data;
            end
          end
        end
        S_ISSUE: begin
          r_pq_wrt  <= 1'b0;
          r_pq_read <= 1'b0;
          // The root seen during the command cycle is the value being popped.
          if (r_need_rsp) begin
            r_rsp_data        <= i_pq_top;
            r_rsp_valid[r_id] <= 1'b1;
          end
          if (SETTLE_CYCLES == 0) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_SETTLE;
            r_cnt   <= CNT_INIT;
          end
        end
        S_SETTLE: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_access_scheduler.sv
// Directed bench for pq_access_scheduler with NUM_REQ=4, DATA_WIDTH=16, SETTLE_CYCLES=2;
// every expected value is hand-computed from the arbitration and timing rules.
module tb_pq_access_scheduler;

  localparam int NR = 4;
  localparam int DW = 16;

  logic                 clk;
  logic                 rst_n;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0][1:0]   req_op;
  logic [NR-1:0][DW-1:0] req_data;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0]        rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 drop;
  logic                 busy;
  logic                 pq_wrt;
  logic                 pq_read;
  logic [DW-1:0]        pq_data;
  logic                 pq_full;
  logic                 pq_empty;
  logic [DW-1:0]        pq_top;

  int total = 0;
  int bad   = 0;

  pq_access_scheduler #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .SETTLE_CYCLES(2)
  ) dut (
    .i_CLK       (clk),
    .i_RSTn      (rst_n),
    .i_req_valid (req_valid),
    .i_req_op    (req_op),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_drop      (drop),
    .o_busy      (busy),
    .o_pq_wrt    (pq_wrt),
    .o_pq_read   (pq_read),
    .o_pq_data   (pq_data),
    .i_pq_full   (pq_full),
    .i_pq_empty  (pq_empty),
    .i_pq_top    (pq_top)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " ready"}, 64'(req_ready), 64'h0);
    check({tag, " busy"},  64'(busy), 64'h0);
    check({tag, " wrt"},   64'(pq_wrt), 64'h0);
    check({tag, " read"},  64'(pq_read), 64'h0);
    check({tag, " rspv"},  64'(rsp_valid), 64'h0);
    check({tag, " drop"},  64'(drop), 64'h0);
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_data  = '0;
    pq_full   = 1'b0;
    pq_empty  = 1'b1;
    pq_top    = '0;

    // Reset: a pending request must not see ready while reset is held.
    req_valid[0] = 1'b1; req_op[0] = 2'b01; req_data[0] = 16'h0005;
    #2;
    check_quiet("rst");
    check("rst pq_data",  64'(pq_data), 64'h0);
    check("rst rsp_data", 64'(rsp_data), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    req_valid = '0;
    tick();

    // Single enqueue timing: grant T, issue T+1, settle T+2..T+3, next grant T+4.
    req_valid[0] = 1'b1; req_op[0] = 2'b01; req_data[0] = 16'h0005;
    #1;
    check("enq ready T", 64'(req_ready), 64'b0001);
    check("enq busy T",  64'(busy), 64'h0);
    tick();
    req_valid[0] = 1'b0;
    check("enq wrt T+1",  64'(pq_wrt), 64'h1);
    check("enq read T+1", 64'(pq_read), 64'h0);
    check("enq data T+1", 64'(pq_data), 64'h0005);
    check("enq busy T+1", 64'(busy), 64'h1);
    check("enq rdy T+1",  64'(req_ready), 64'h0);
    tick();
    check("enq wrt T+2",  64'(pq_wrt), 64'h0);
    check("enq busy T+2", 64'(busy), 64'h1);
    tick();
    check("enq busy T+3", 64'(busy), 64'h1);
    tick();
    check("enq busy T+4", 64'(busy), 64'h0);

    // All four enqueue continuously; last winner was 0, so order is 1,2,3,0,1.
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = 1'b1; req_op[i] = 2'b01; req_data[i] = 16'(i + 1);
    end
    begin
      int exp_order[5] = '{1, 2, 3, 0, 1};
      for (int k = 0; k < 5; k++) begin
        #1;
        check($sformatf("rr grant %0d", k), 64'(req_ready), 64'(1 << exp_order[k]));
        tick();
        check($sformatf("rr wrt %0d", k),  64'(pq_wrt), 64'h1);
        check($sformatf("rr data %0d", k), 64'(pq_data), 64'(exp_order[k] + 1));
        tick();
        tick();
        tick();
      end
    end
    req_valid = '0;

    // Deq blocked on empty while an enqueue from another requester proceeds.
    req_valid[1] = 1'b1; req_op[1] = 2'b10; req_data[1] = 16'h0000;
    req_valid[2] = 1'b1; req_op[2] = 2'b01; req_data[2] = 16'h0033;
    #1;
    check("empty skip ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid[2] = 1'b0;
    check("empty enq wrt",  64'(pq_wrt), 64'h1);
    check("empty enq data", 64'(pq_data), 64'h0033);
    tick();
    tick();
    tick();
    check("deq stalled ready", 64'(req_ready), 64'h0);
    check("deq stalled busy",  64'(busy), 64'h0);
    pq_empty = 1'b0; pq_top = 16'h0042;
    #1;
    check("deq ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid[1] = 1'b0;
    check("deq read",  64'(pq_read), 64'h1);
    check("deq wrt",   64'(pq_wrt), 64'h0);
    check("deq rspv early", 64'(rsp_valid), 64'h0);
    tick();
    check("deq rspv", 64'(rsp_valid), 64'b0010);
    check("deq rspd", 64'(rsp_data), 64'h0042);
    check("deq read off", 64'(pq_read), 64'h0);
    tick();
    check("deq rspv pulse", 64'(rsp_valid), 64'h0);
    check("deq rspd hold",  64'(rsp_data), 64'h0042);
    tick();

    // Full queue: enqueue stalls, replace still goes through and returns the old root.
    pq_full = 1'b1;
    req_valid[0] = 1'b1; req_op[0] = 2'b01; req_data[0] = 16'h0007;
    req_valid[3] = 1'b1; req_op[3] = 2'b11; req_data[3] = 16'h0009;
    #1;
    check("full repl ready", 64'(req_ready), 64'b1000);
    tick();
    req_valid[3] = 1'b0;
    check("repl wrt",  64'(pq_wrt), 64'h1);
    check("repl read", 64'(pq_read), 64'h1);
    check("repl data", 64'(pq_data), 64'h0009);
    pq_top = 16'h0040;
    tick();
    check("repl rspv", 64'(rsp_valid), 64'b1000);
    check("repl rspd", 64'(rsp_data), 64'h0040);
    tick();
    tick();
    check("full enq stalled", 64'(req_ready), 64'h0);
    pq_full = 1'b0;
    #1;
    check("unfull enq ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid[0] = 1'b0;
    check("unfull enq data", 64'(pq_data), 64'h0007);
    tick();
    tick();
    tick();

    // Zero-key enqueue is dropped; the following grant happens the very next cycle.
    req_valid[0] = 1'b1; req_op[0] = 2'b01; req_data[0] = 16'h0000;
    #1;
    check("drop ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_op[1] = 2'b01; req_data[1] = 16'h0011;
    #1;
    check("drop pulse", 64'(drop), 64'h1);
    check("drop wrt",   64'(pq_wrt), 64'h0);
    check("drop read",  64'(pq_read), 64'h0);
    check("drop busy",  64'(busy), 64'h0);
    check("post drop ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid[1] = 1'b0;
    check("drop clears", 64'(drop), 64'h0);
    check("post drop wrt",  64'(pq_wrt), 64'h1);
    check("post drop data", 64'(pq_data), 64'h0011);
    tick();
    tick();
    tick();

    // Illegal op is dropped with no response.
    req_valid[2] = 1'b1; req_op[2] = 2'b00; req_data[2] = 16'h0005;
    #1;
    check("illegal ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid[2] = 1'b0;
    check("illegal drop", 64'(drop), 64'h1);
    check("illegal rspv", 64'(rsp_valid), 64'h0);
    check("illegal busy", 64'(busy), 64'h0);
    tick();

    // Reset asserted during settle clears everything; req0 wins first afterwards.
    req_valid[2] = 1'b1; req_op[2] = 2'b01; req_data[2] = 16'h0077;
    #1;
    check("pre-rst ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid[2] = 1'b0;
    tick();
    check("pre-rst busy", 64'(busy), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    check("midrst pq_data",  64'(pq_data), 64'h0);
    check("midrst rsp_data", 64'(rsp_data), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check_quiet("postrst");
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = 1'b1; req_op[i] = 2'b01; req_data[i] = 16'(i + 8);
    end
    #1;
    check("postrst first grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    check("postrst wrt",  64'(pq_wrt), 64'h1);
    check("postrst data", 64'(pq_data), 64'h0008);
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
